// File: rtl/dma_sequencer.sv
// dma_sequencer: cartridge transfer engine. Takes the glue's Execute pulse,
// drives DMA/DMARW for the bus glue, steps the C64/RAM address and length
// counters one byte per PHI2 cycle (two for swap), stalls while BA is low and
// reports EOB/Fault/IRQ status.
module dma_sequencer #(
    parameter int RAW = 24,
    parameter int LW  = 16
) (
    input  logic           PHI2,
    input  logic           nRES,
    input  logic           Execute,
    input  logic [1:0]     Cmd,
    input  logic [15:0]    C64AInit,
    input  logic [RAW-1:0] RAMAInit,
    input  logic [LW-1:0]  LenInit,
    input  logic           FixC64,
    input  logic           FixRAM,
    input  logic           Autoload,
    input  logic           IntEnEOB,
    input  logic           IntEnFault,
    input  logic           StatusRD,
    input  logic           BA,
    input  logic [7:0]     C64D,
    input  logic [7:0]     RAMD,
    output logic           DMA,
    output logic           DMARW,
    output logic [15:0]    C64A,
    output logic [RAW-1:0] RAMA,
    output logic [LW-1:0]  LenCur,
    output logic [7:0]     C64Dout,
    output logic [7:0]     RAMDout,
    output logic           RAMnCE,
    output logic           RAMnWE,
    output logic           Busy,
    output logic           EOB,
    output logic           Fault,
    output logic           IRQ
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_XFER, S_SWAPW, S_FINISH} state_t;
    typedef enum logic [1:0] {CMD_STASH, CMD_FETCH, CMD_SWAP, CMD_VERIFY} cmd_t;

    state_t         state_q, state_d;
    cmd_t           cmd_q, cmd_d;
    logic [15:0]    c64a_q, c64a_d;
    logic [RAW-1:0] rama_q, rama_d;
    logic [LW-1:0]  len_q, len_d;
    logic [7:0]     c64_lat_q, c64_lat_d;
    logic [7:0]     ram_lat_q, ram_lat_d;
    logic           dma_q, dma_d;
    logic           dmarw_q, dmarw_d;
    logic           busy_q, busy_d;
    logic           eob_q, eob_d;
    logic           fault_q, fault_d;
    logic           irq_q, irq_d;

    logic accept, byte_done, set_eob, set_fault, xfer_go;

    // Next-state, counter and status-flag computation for the whole sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        cmd_d     = cmd_q;
        c64a_d    = c64a_q;
        rama_d    = rama_q;
        len_d     = len_q;
        c64_lat_d = c64_lat_q;
        ram_lat_d = ram_lat_q;
        dma_d     = dma_q;
        dmarw_d   = dmarw_q;
        busy_d    = busy_q;
        accept    = 1'b0;
        byte_done = 1'b0;
        set_eob   = 1'b0;
        set_fault = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Execute) begin
                    accept  = 1'b1;
                    state_d = S_ARM;
                    cmd_d   = cmd_t'(Cmd);
                    c64a_d  = C64AInit;
                    rama_d  = RAMAInit;
                    len_d   = LenInit;
                    busy_d  = 1'b1;
                    dma_d   = 1'b1;
                    dmarw_d = 1'b1;
                end
            end
            S_ARM: begin
                // Bus direction for the first transfer cycle; only fetch writes the C64.
                state_d = S_XFER;
                dmarw_d = (cmd_q != CMD_FETCH);
            end
            S_XFER: begin
                if (BA) begin
                    case (cmd_q)
                        CMD_SWAP: begin
                            c64_lat_d = C64D;
                            ram_lat_d = RAMD;
                            dmarw_d   = 1'b0;
                            state_d   = S_SWAPW;
                        end
                        CMD_VERIFY: begin
                            byte_done = 1'b1;
                            set_fault = (C64D != RAMD);
                        end
                        default: byte_done = 1'b1;
                    endcase
                end
            end
            S_SWAPW: begin
                if (BA) begin
                    byte_done = 1'b1;
                    dmarw_d   = 1'b1;
                    state_d   = S_XFER;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (Autoload) begin
                    c64a_d = C64AInit;
                    rama_d = RAMAInit;
                    len_d  = LenInit;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completed byte advances the addresses; the last byte leaves LenCur at 1.
        if (byte_done) begin
            if (!FixC64) c64a_d = c64a_q + 16'd1;
            if (!FixRAM) rama_d = rama_q + RAW'(1);
            if (len_q == LW'(1)) set_eob = 1'b1;
            else                 len_d   = len_q - LW'(1);
        end

        if (set_eob || set_fault) begin
            state_d = S_FINISH;
            dma_d   = 1'b0;
            busy_d  = 1'b0;
            dmarw_d = 1'b1;
        end

        // A flag being set outranks a coincident status read.
        eob_d   = set_eob   ? 1'b1 : ((accept || StatusRD) ? 1'b0 : eob_q);
        fault_d = set_fault ? 1'b1 : ((accept || StatusRD) ? 1'b0 : fault_q);
        irq_d   = (eob_d & IntEnEOB) | (fault_d & IntEnFault);
    end

    // State register; nRES drops DMA and every flag without waiting for PHI2.
    always_ff @(posedge PHI2 or negedge nRES) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!nRES) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_STASH;
            c64a_q    <= '0;
            rama_q    <= '0;
            len_q     <= '0;
            c64_lat_q <= '0;
            ram_lat_q <= '0;
            dma_q     <= 1'b0;
            dmarw_q   <= 1'b1;
            busy_q    <= 1'b0;
            eob_q     <= 1'b0;
            fault_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            c64a_q    <= c64a_d;
            rama_q    <= rama_d;
            len_q     <= len_d;
            c64_lat_q <= c64_lat_d;
            ram_lat_q <= ram_lat_d;
            dma_q     <= dma_d;
            dmarw_q   <= dmarw_d;
            busy_q    <= busy_d;
            eob_q     <= eob_d;
            fault_q   <= fault_d;
            irq_q     <= irq_d;
        end
    end

    // RAM strobes are live only in a transfer cycle where VIC has released the bus.
    assign xfer_go = BA && (state_q == S_XFER || state_q == S_SWAPW);
    assign RAMnCE  = ~xfer_go;
    assign RAMnWE  = ~(xfer_go && (state_q == S_SWAPW || cmd_q == CMD_STASH));

    // Stash/fetch pass data straight through; swap writes back the latched bytes.
    assign RAMDout = (state_q == S_XFER && cmd_q == CMD_STASH) ? C64D : c64_lat_q;
    assign C64Dout = (state_q == S_XFER && cmd_q == CMD_FETCH) ? RAMD : ram_lat_q;

    assign DMA    = dma_q;
    assign DMARW  = dmarw_q;
    assign C64A   = c64a_q;
    assign RAMA   = rama_q;
    assign LenCur = len_q;
    assign Busy   = busy_q;
    assign EOB    = eob_q;
    assign Fault  = fault_q;
    assign IRQ    = irq_q;

endmodule

// File: doc/dma_sequencer.md
Name: dma_sequencer

Overview:
- Transfer engine for the cartridge. It sits upstream of the bus glue: it consumes the glue's Execute pulse and produces the DMA and DMARW commands that the glue turns into buffer enables and the C64 DMA line.
- It also produces the IRQ and status flags.
- Each operation moves bytes between C64 memory and expansion RAM: stash, fetch, swap or verify.
- It runs one byte per PHI2 cycle, or two per byte for swap, and stalls whenever VIC holds BA low.

Parameters:
- RAW, 24, expansion RAM address width (address wraps modulo 2^RAW).
- LW, 16, length counter width (a length of 0 means 2^LW bytes).

Ports:
- PHI2  in  1  system clock; all state updates on the rising edge.
- nRES  in  1  asynchronous active-low reset.
- Execute  in  1  one-cycle start pulse from the glue; ignored while Busy.
- Cmd  in  2  operation: 0 = stash (C64 to RAM), 1 = fetch (RAM to C64), 2 = swap, 3 = verify.
- C64AInit  in  16  C64 start address.
- RAMAInit  in  RAW  RAM start address.
- LenInit  in  LW  byte count.
- FixC64, FixRAM  in  1 each  hold the corresponding address constant.
- Autoload  in  1  reload counters from the Init values at the end of the operation.
- IntEnEOB, IntEnFault  in  1 each  interrupt enables.
- StatusRD  in  1  status register read strobe; clears EOB, Fault and IRQ.
- BA  in  1  C64 bus available.
- C64D  in  8  C64 data bus input.
- RAMD  in  8  RAM data input.
- DMA  out  1  DMA request to the glue and C64.
- DMARW  out  1  1 = read C64, 0 = write C64.
- C64A  out  16  current C64 address.
- RAMA  out  RAW  current RAM address.
- LenCur  out  LW  current remaining count.
- C64Dout  out  8  data to write to the C64.
- RAMDout  out  8  data to write to RAM.
- RAMnCE, RAMnWE  out  1 each  RAM strobes.
- Busy, EOB, Fault, IRQ  out  1 each  status flags.

Behaviour:
- Reset (async, nRES=0):
  - State IDLE.
  - DMA=0, DMARW=1, RAMnCE=1, RAMnWE=1.
  - Busy, EOB, Fault and IRQ all 0.
  - Counters = 0; data latches = 0.
  - Assertion mid-transfer aborts immediately; DMA drops without waiting for a clock.
- States: IDLE, ARM, XFER, SWAPW, FINISH.
- IDLE:
  - Execute=1 at an edge loads C64A, RAMA and LenCur from the Init values and latches Cmd.
  - Sets Busy=1 and clears EOB and Fault.
  - Next state ARM.
- ARM:
  - DMA=1 registered.
  - Goes to XFER on the next edge regardless of BA.
  - No byte is moved in ARM.
- XFER: a byte completes at an edge where BA=1.
  - stash: DMARW=1; RAMDout=C64D; RAMnCE=0 and RAMnWE=0 during the cycle.
  - fetch: DMARW=0; C64Dout=RAMD; RAMnCE=0, RAMnWE=1.
  - verify: DMARW=1; RAMnCE=0, RAMnWE=1; C64D and RAMD are compared at the edge.
  - swap: DMARW=1; both C64D and RAMD are latched at the edge, RAM is read only, next state SWAPW, and counters do not advance yet.
- SWAPW:
  - DMARW=0; C64Dout = latched RAM byte; RAMDout = latched C64 byte; RAMnCE=0, RAMnWE=0.
  - At an edge with BA=1 the byte completes and the state returns to XFER.
- Stall (BA=0 in XFER or SWAPW):
  - State, counters and latches hold.
  - RAMnCE=1 and RAMnWE=1.
  - DMA stays 1; DMARW holds its value.
- Byte completion:
  - C64A increments unless FixC64; it wraps FFFF to 0000.
  - RAMA increments unless FixRAM; it wraps modulo 2^RAW.
  - If LenCur==1 the state goes to FINISH; otherwise LenCur decrements.
  - LenInit=0 therefore transfers 2^LW bytes.
- Verify mismatch:
  - Fault=1; counters still advance for the mismatching byte; state goes to FINISH.
  - A mismatch on the last byte sets both Fault and EOB.
- FINISH (one cycle), then IDLE:
  - DMA=0, Busy=0.
  - EOB=1 if the length was exhausted.
  - Without Autoload, LenCur reads 1 and the addresses point one past the last byte.
  - With Autoload, all three counters are reloaded from the Init values.
- IRQ = (EOB & IntEnEOB) | (Fault & IntEnFault), registered.
  - StatusRD clears EOB, Fault and IRQ at the edge.
  - If a flag set and StatusRD coincide at the same edge, the set wins.
- Execute while Busy is ignored; the Init inputs are sampled only at accept.

Test Plan:
- Stash: Cmd=0, C64AInit=1000, RAMAInit=000000, LenInit=4, BA=1 -> DMA high 5 cycles after Execute (ARM plus 4 transfers), RAMA bytes match C64 1000-1003, C64A=1004, LenCur=1, EOB=1.
- Fetch with stall: Cmd=1, LenInit=3, BA low for 2 cycles mid-transfer -> RAM strobes high during the stall, counters frozen, 3 bytes written, DMA high 6 cycles.
- Swap: Cmd=2, LenInit=2, C64 holds AA 55, RAM holds 11 22 -> swap takes 4 transfer cycles; afterwards C64 holds 11 22 and RAM holds AA 55.
- Verify: Cmd=3, LenInit=8, mismatch at byte 3 with IntEnFault=1 -> Fault=1, IRQ=1, EOB=0, C64A=start+3, LenCur=5; StatusRD clears all three.
- Edge cases:
  - LenInit=0 with FixC64=1 -> 65536 transfers and C64A constant.
  - RAMAInit=FFFFFF, LenInit=2 -> RAM addresses FFFFFF then 000000.
  - Autoload=1 -> counters equal the Init values after FINISH.
- Robustness:
  - Execute pulsed while Busy -> ignored.
  - nRES low mid-transfer -> DMA=0 asynchronously and all flags 0.
